lsu_mem_if: RTL and testbench

- Load/store unit directly downstream of the control decoder in the RV32I core.
- Consumes MemRW, RSel and WSel from the control decoder, the ALU result as address, and rs2 as store data.
- Formats byte lanes and runs a valid/grant/response handshake to data memory.
- Asserts Stall until the access completes, then returns sign- or zero-extended load data to the write-back mux (WBSel=00).

---
 rtl/rv_mem_pkg.sv | 63 ++++++
 rtl/lsu_lane_fmt.sv | 42 ++++
 rtl/lsu_mem_if.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_if.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I load/store path: select codes, access
// descriptor and the memory-interface FSM states.
package rv_mem_pkg;

  localparam int unsigned RSEL_W = 3;
  localparam int unsigned WSEL_W = 2;

  localparam logic [RSEL_W-1:0] RS_LW   = 3'b000;
  localparam logic [RSEL_W-1:0] RS_LB   = 3'b001;
  localparam logic [RSEL_W-1:0] RS_LH   = 3'b010;
  localparam logic [RSEL_W-1:0] RS_LBU  = 3'b101;
  localparam logic [RSEL_W-1:0] RS_LHU  = 3'b110;
  localparam logic [RSEL_W-1:0] RS_NONE = 3'b111;

  localparam logic [WSEL_W-1:0] WS_SW   = 2'b00;
  localparam logic [WSEL_W-1:0] WS_SB   = 2'b01;
  localparam logic [WSEL_W-1:0] WS_SH   = 2'b10;
  localparam logic [WSEL_W-1:0] WS_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef struct packed {
    logic  sgn;
    size_t size;
  } acc_t;

  // Access width and signedness; stores always take their width from WSel.
  function automatic acc_t decode_acc(input logic store,
                                      input logic [RSEL_W-1:0] rsel,
                                      input logic [WSEL_W-1:0] wsel);
    acc_t a;
    a.sgn  = 1'b0;
    a.size = SZ_W;
    if (store) begin
      case (wsel)
        WS_SB:   a.size = SZ_B;
        WS_SH:   a.size = SZ_H;
        default: a.size = SZ_W;
      endcase
    end else begin
      case (rsel)
        RS_LB:   begin a.sgn = 1'b1; a.size = SZ_B; end
        RS_LH:   begin a.sgn = 1'b1; a.size = SZ_H; end
        RS_LBU:  a.size = SZ_B;
        RS_LHU:  a.size = SZ_H;
        default: a.size = SZ_W;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting: store enables/replication, load extraction and
// extension, and alignment check for one access descriptor.
module lsu_lane_fmt
  import rv_mem_pkg::*;
(
  input  acc_t        acc,
  input  logic [1:0]  off,
  input  logic [31:0] dataw,
  input  logic [31:0] rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ldata_c,
  output logic        misalign_c
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    be_c       = 4'b1111;
    wdata_c    = dataw;
    ldata_c    = shifted;
    misalign_c = 1'b0;
    case (acc.size)
      SZ_B: begin
        be_c       = 4'b0001 << off;
        wdata_c    = {4{dataw[7:0]}};
        ldata_c    = {{24{acc.sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be_c       = off[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{dataw[15:0]}};
        ldata_c    = {{16{acc.sgn & shifted[15]}}, shifted[15:0]};
        misalign_c = off[0];
      end
      default: begin
        misalign_c = |off;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: decodes the access, runs the req/gnt/rvalid handshake to
// data memory and returns formatted load data while stalling the core.
module lsu_mem_if
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRW,
  input  logic [RSEL_W-1:0] RSel,
  input  logic [WSEL_W-1:0] WSel,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataW,
  output logic [31:0]       DataR,
  output logic              Stall,
  output logic              MisAlign,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned     CNT_W    = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              store_c, load_c, access_c, go_c, tmo_c;
  acc_t              cur_acc_c, lat_acc, fmt_acc_c;
  logic [1:0]        lat_off, fmt_off_c;
  logic [3:0]        fmt_be_c;
  logic [31:0]       fmt_wdata_c, fmt_ldata_c;
  logic              fmt_mis_c;
  logic [CNT_W-1:0]  cnt;

  // Store wins over load; unlisted select codes are no access.
  always_comb begin
    store_c   = MemRW && (WSel != WS_NONE);
    load_c    = !store_c && (RSel inside {RS_LW, RS_LB, RS_LH, RS_LBU, RS_LHU});
    access_c  = store_c || load_c;
    cur_acc_c = decode_acc(store_c, RSel, WSel);
  end

  // The formatter sees live inputs in IDLE and the latched access afterwards.
  always_comb begin
    fmt_acc_c = (state == ST_IDLE) ? cur_acc_c : lat_acc;
    fmt_off_c = (state == ST_IDLE) ? Addr[1:0] : lat_off;
  end

  lsu_lane_fmt u_fmt (
    .acc        (fmt_acc_c),
    .off        (fmt_off_c),
    .dataw      (DataW),
    .rdata      (mem_rdata),
    .be_c       (fmt_be_c),
    .wdata_c    (fmt_wdata_c),
    .ldata_c    (fmt_ldata_c),
    .misalign_c (fmt_mis_c)
  );

  assign go_c  = access_c && !fmt_mis_c;
  assign tmo_c = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (go_c) state_nx = ST_REQ;
      ST_REQ:  if (mem_gnt) state_nx = ST_WAIT;
      ST_WAIT: if (mem_rvalid || tmo_c) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    Stall    = 1'b0;
    MisAlign = 1'b0;
    case (state)
      ST_IDLE: begin
        Stall    = go_c && !rst;
        MisAlign = access_c && fmt_mis_c && !rst;
      end
      ST_REQ, ST_WAIT: Stall = 1'b1;
      default: ;
    endcase
  end

  // Request fields, timeout counter and load-result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      DataR     <= '0;
      BusErr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      lat_acc   <= '0;
      lat_off   <= '0;
    end else begin
      BusErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_c) begin
            mem_req   <= 1'b1;
            mem_we    <= store_c;
            mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
            mem_be    <= fmt_be_c;
            mem_wdata <= fmt_wdata_c;
            lat_acc   <= cur_acc_c;
            lat_off   <= Addr[1:0];
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_rvalid) begin
            if (!mem_we) DataR <= fmt_ldata_c;
          end else if (tmo_c) begin
            DataR  <= '0;
            BusErr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomised bench for lsu_mem_if: a reactive memory slave plus a byte-level
// reference memory predicting timing, request fields and load results.
module tb_lsu_mem_if;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRW = 1'b0;
  logic [2:0]  RSel = 3'b111;
  logic [1:0]  WSel = 2'b11;
  logic [31:0] Addr = '0;
  logic [31:0] DataW = '0;
  logic [31:0] DataR;
  logic        Stall, MisAlign, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT(T), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .MemRW(MemRW), .RSel(RSel), .WSel(WSel),
    .Addr(Addr), .DataW(DataW), .DataR(DataR), .Stall(Stall),
    .MisAlign(MisAlign), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [0:127];
  logic [31:0] smem [0:31];
  logic [31:0] model_datar = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int nbytes_of(input logic st, input logic [2:0] rs, input logic [1:0] ws);
    if (st) return (ws == 2'b01) ? 1 : (ws == 2'b10) ? 2 : 4;
    if (rs == 3'b001 || rs == 3'b101) return 1;
    if (rs == 3'b010 || rs == 3'b110) return 2;
    return 4;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    smem[addr[6:2]] = word;
    for (int i = 0; i < 4; i++) ref_mem[{addr[6:2], 2'b00} + 7'(i)] = word[8*i +: 8];
  endtask

  // One instruction from presentation to retirement (first cycle with Stall=0).
  task automatic run_instr(input logic memrw, input logic [2:0] rsel, input logic [1:0] wsel,
                           input logic [31:0] addr, input logic [31:0] dataw,
                           input int g, input int r,
                           output logic [31:0] o_datar, output logic [31:0] o_addr,
                           output logic [3:0] o_be, output logic [31:0] o_wdata,
                           output int o_stall, output int o_buserr, output logic o_mis);
    logic st, ld, acc, aligned, go, tmo, in_wait;
    int nb, off, w, total, req_cnt, wcnt;
    logic [31:0] val, exp_data, exp_wdata, exp_maddr;
    logic [3:0] exp_be;
    st      = memrw && (wsel != 2'b11);
    ld      = !st && (rsel inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110});
    acc     = st || ld;
    nb      = nbytes_of(st, rsel, wsel);
    off     = int'(addr[1:0]);
    aligned = (off % nb) == 0;
    go      = acc && aligned;
    tmo     = r >= int'(T);
    w       = tmo ? int'(T) : r + 1;
    total   = go ? g + w + 3 : 1;
    exp_be  = '0;
    for (int i = 0; i < nb; i++) if (off + i < 4) exp_be[off + i] = 1'b1;
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = dataw[8*(i % nb) +: 8];
    exp_maddr = {addr[31:2], 2'b00};
    val = '0;
    for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[(int'(addr[6:0]) + i) % 128];
    if ((rsel == 3'b001 || rsel == 3'b010) && nb < 4 && val[8*nb-1])
      val = val | ~((32'h1 << (8*nb)) - 32'h1);
    exp_data = model_datar;
    if (go) exp_data = tmo ? 32'h0 : (ld ? val : model_datar);

    o_datar = '0; o_addr = '0; o_be = '0; o_wdata = '0;
    o_stall = 0; o_buserr = 0; o_mis = 1'b0;
    req_cnt = 0; in_wait = 1'b0; wcnt = 0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        MemRW = memrw; RSel = rsel; WSel = wsel; Addr = addr; DataW = dataw;
      end
      mem_gnt = mem_req && (req_cnt == g);
      if (in_wait && wcnt == r) begin
        mem_rvalid = 1'b1;
        mem_rdata  = smem[addr[6:2]];
      end else if (in_wait) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end else begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
      end
      #1;
      chk("stall",    32'(Stall),    32'(go && k < total - 1));
      chk("misalign", 32'(MisAlign), 32'(acc && !aligned));
      chk("mem_req",  32'(mem_req),  32'(go && k >= 1 && k <= g + 1));
      chk("buserr",   32'(BusErr),   32'(go && tmo && k == total - 1));
      if (mem_req && go) begin
        chk("mem_addr",  mem_addr,      exp_maddr);
        chk("mem_we",    32'(mem_we),   32'(st));
        chk("mem_be",    32'(mem_be),   32'(exp_be));
        chk("mem_wdata", mem_wdata,     exp_wdata);
      end
      if (k == 0) o_mis = MisAlign;
      if (Stall) o_stall++;
      if (BusErr) o_buserr++;
      if (k == total - 1) begin
        chk("datar", DataR, exp_data);
        o_datar = DataR;
      end
      if (mem_gnt) begin
        o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        if (mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) smem[mem_addr[6:2]][8*i +: 8] = mem_wdata[8*i +: 8];
        in_wait = 1'b1; wcnt = 0; req_cnt = 0;
      end else if (in_wait) begin
        if (wcnt == r || wcnt == int'(T) - 1) in_wait = 1'b0;
        else wcnt++;
      end else if (mem_req) begin
        req_cnt++;
      end
    end
    if (go && st)
      for (int i = 0; i < nb; i++) ref_mem[(int'(addr[6:0]) + i) % 128] = dataw[8*i +: 8];
    model_datar = exp_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; MemRW = 1'b0; RSel = 3'b000; WSel = 2'b11; Addr = 32'h100;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("rst_stall",  32'(Stall),    32'h0);
    chk("rst_mis",    32'(MisAlign), 32'h0);
    chk("rst_req",    32'(mem_req),  32'h0);
    chk("rst_datar",  DataR,         32'h0);
    chk("rst_buserr", 32'(BusErr),   32'h0);
    chk("rst_be",     32'(mem_be),   32'h0);
    chk("rst_wdata",  mem_wdata,     32'h0);
    @(negedge clk);
    rst = 1'b0; RSel = 3'b111;
    model_datar = '0;
  endtask

  logic [31:0] d, a, wd;
  logic [3:0]  be;
  int          sc, be_cnt;
  logic        mis;

  initial begin
    for (int i = 0; i < 32; i++) preload({25'h4, 5'(i), 2'b00}, $urandom);
    do_reset();

    // Store word, single-cycle grant and next-cycle response.
    run_instr(1'b1, 3'b111, 2'b00, 32'h100, 32'hDEADBEEF, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("sw_addr", a, 32'h100);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_wdata", wd, 32'hDEADBEEF);
    chk("sw_stall", 32'(sc), 32'd3);

    preload(32'h200, 32'h80FF7F01);
    run_instr(1'b0, 3'b001, 2'b11, 32'h203, 32'h0, 1, 1, d, a, be, wd, sc, be_cnt, mis);
    chk("lb", d, 32'hFFFFFF80);
    run_instr(1'b0, 3'b101, 2'b11, 32'h203, 32'h0, 0, 2, d, a, be, wd, sc, be_cnt, mis);
    chk("lbu", d, 32'h00000080);
    run_instr(1'b0, 3'b010, 2'b11, 32'h202, 32'h0, 2, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("lh", d, 32'hFFFF80FF);
    run_instr(1'b0, 3'b110, 2'b11, 32'h200, 32'h0, 0, 3, d, a, be, wd, sc, be_cnt, mis);
    chk("lhu", d, 32'h00007F01);

    run_instr(1'b1, 3'b111, 2'b10, 32'h206, 32'h0000ABCD, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wd, 32'hABCDABCD);
    run_instr(1'b1, 3'b111, 2'b01, 32'h201, 32'h00000055, 1, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wd, 32'h55555555);

    run_instr(1'b0, 3'b000, 2'b11, 32'h102, 32'h0, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("lw_mis", 32'(mis), 32'h1);
    chk("lw_mis_stall", 32'(sc), 32'h0);
    run_instr(1'b1, 3'b111, 2'b10, 32'h101, 32'h1234, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("sh_mis", 32'(mis), 32'h1);

    // Timeout: granted but never answered.
    run_instr(1'b0, 3'b000, 2'b11, 32'h200, 32'h0, 1, int'(T), d, a, be, wd, sc, be_cnt, mis);
    chk("tmo_datar", d, 32'h0);
    chk("tmo_buserr", 32'(be_cnt), 32'd1);
    chk("tmo_stall", 32'(sc), 32'd7);
    run_instr(1'b0, 3'b111, 2'b11, 32'h200, 32'h0, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("post_tmo_datar", d, 32'h0);

    run_instr(1'b0, 3'b000, 2'b11, 32'h200, 32'h0, 0, 1, d, a, be, wd, sc, be_cnt, mis);
    chk("lw_after_sb", d, 32'h80FF5501);

    // Reset while waiting for a response.
    @(negedge clk);
    MemRW = 1'b0; RSel = 3'b000; WSel = 2'b11; Addr = 32'h100;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = mem_req;
    #1 chk("rw_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1 chk("rw_wait_stall", 32'(Stall), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rw_req_clr", 32'(mem_req), 32'h0);
    chk("rw_datar_clr", DataR, 32'h0);
    chk("rw_stall_rst", 32'(Stall), 32'h0);
    rst = 1'b0; RSel = 3'b111; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("rw_late_rvalid", DataR, 32'h0);
    model_datar = '0;
    run_instr(1'b0, 3'b000, 2'b11, 32'h100, 32'h0, 0, 0, d, a, be, wd, sc, be_cnt, mis);
    chk("rw_lw_stall", 32'(sc), 32'd3);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = 32'h200 | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_instr(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                ra, $urandom, $urandom_range(0, 3), $urandom_range(0, int'(T)),
                d, a, be, wd, sc, be_cnt, mis);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
